// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing for the 5-stage MIPS core.
// Detects load-use (and MFC0-use) hazards between EX and ID, sequences the
// multi-cycle divider, and turns MEM-stage exception requests into a
// two-cycle flush. All control outputs are combinational from state, counter
// and inputs; only stall_cycles is registered.
//
// Divider handshake: ex_div_start is a level, sampled only while IDLE. Once
// accepted, the divider owns EX for DIV_LATENCY cycles (start cycle included).
// div_done pulses in the first cycle the pipeline is released. div_abort
// pulses instead if an exception cancels the divide.
module hazard_stall_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_read_en_1,
    input  logic [4:0]       id_read_addr_1,
    input  logic             id_read_en_2,
    input  logic [4:0]       id_read_addr_2,
    input  logic             ex_write_en,
    input  logic [4:0]       ex_write_addr,
    input  logic             ex_is_load,
    input  logic             ex_div_start,
    input  logic             exc_req,
    output logic [5:0]       stall,
    output logic             ex_bubble,
    output logic             flush,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_abort,
    output logic [31:0]      stall_cycles,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // Stall patterns, bit order {wb,mem,ex,id,if,pc}.
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    localparam logic [5:0] STALL_LOAD = 6'b000111;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q;

    logic             hazard;
    logic [5:0]       stall_raw;
    logic             bubble_raw;
    logic             flush_raw;
    logic             busy_raw;
    logic             done_raw;
    logic             abort_raw;

    // Load-use hazard: a load/MFC0 in EX writes a real GPR that ID reads.
    assign hazard = ex_is_load & ex_write_en & (ex_write_addr != 5'd0) &
                    ((id_read_en_1 & (id_read_addr_1 == ex_write_addr)) |
                     (id_read_en_2 & (id_read_addr_2 == ex_write_addr)));

    // State and divider countdown register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and raw outputs; priority is exception > divide > hazard.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_raw  = '0;
        bubble_raw = 1'b0;
        flush_raw  = 1'b0;
        busy_raw   = 1'b0;
        done_raw   = 1'b0;
        abort_raw  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    flush_raw = 1'b1;
                    state_d   = ST_FLUSH;
                end else if (ex_div_start) begin
                    stall_raw = STALL_DIV;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_DIV_WAIT;
                end else if (hazard) begin
                    stall_raw  = STALL_LOAD;
                    bubble_raw = 1'b1;
                end
            end
            ST_DIV_WAIT: begin
                busy_raw = (cnt_q != '0);
                if (exc_req) begin
                    abort_raw = 1'b1;
                    flush_raw = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_FLUSH;
                end else if (cnt_q != '0) begin
                    stall_raw = STALL_DIV;
                    cnt_d     = cnt_q - CNT_ONE;
                end else begin
                    done_raw = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Second flush cycle; a still-high exc_req is the same event.
                flush_raw = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held.
    assign stall     = rst ? 6'b0 : stall_raw;
    assign ex_bubble = rst ? 1'b0 : bubble_raw;
    assign flush     = rst ? 1'b0 : flush_raw;
    assign div_busy  = rst ? 1'b0 : busy_raw;
    assign div_done  = rst ? 1'b0 : done_raw;
    assign div_abort = rst ? 1'b0 : abort_raw;
    assign dbg_state = state_q;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model through a scoreboard.
module tb_hazard_stall_ctrl;

    localparam int DIV_LATENCY = 32;
    localparam int W           = 43;

    typedef struct packed {
        logic [5:0]  stall;
        logic        bubble;
        logic        flush;
        logic        busy;
        logic        done;
        logic        abort;
        logic [31:0] sc;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        id_read_en_1, id_read_en_2;
    logic [4:0]  id_read_addr_1, id_read_addr_2;
    logic        ex_write_en;
    logic [4:0]  ex_write_addr;
    logic        ex_is_load, ex_div_start, exc_req;
    logic [5:0]  stall;
    logic        ex_bubble, flush, div_busy, div_done, div_abort;
    logic [31:0] stall_cycles;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.DIV_LATENCY(DIV_LATENCY), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_read_en_1   (id_read_en_1),
        .id_read_addr_1 (id_read_addr_1),
        .id_read_en_2   (id_read_en_2),
        .id_read_addr_2 (id_read_addr_2),
        .ex_write_en    (ex_write_en),
        .ex_write_addr  (ex_write_addr),
        .ex_is_load     (ex_is_load),
        .ex_div_start   (ex_div_start),
        .exc_req        (exc_req),
        .stall          (stall),
        .ex_bubble      (ex_bubble),
        .flush          (flush),
        .div_busy       (div_busy),
        .div_done       (div_done),
        .div_abort      (div_abort),
        .stall_cycles   (stall_cycles),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Observation counters for the directed scenarios.
    int n_div_stall = 0;
    int n_busy      = 0;
    int n_done      = 0;
    int n_abort     = 0;
    int n_flush     = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    // div_left: cycles the divider still holds after the start cycle
    // (the last of them is the release cycle). flush_next: the previous
    // cycle accepted an exception, so this one is the second flush cycle.
    int          m_div_left   = 0;
    bit          m_flush_next = 0;
    logic [31:0] m_stalls     = 0;

    function automatic logic [W-1:0] model_step(
        input bit r, input bit re1, input bit [4:0] ra1, input bit re2, input bit [4:0] ra2,
        input bit we, input bit [4:0] wa, input bit ld, input bit ds, input bit ex);
        obs_t e;
        bit   reads_dest;
        e = '0;
        if (r) begin
            m_div_left   = 0;
            m_flush_next = 0;
            m_stalls     = 0;
            return e;
        end
        e.sc = m_stalls;
        reads_dest = (re1 && ra1 == wa) || (re2 && ra2 == wa);
        if (m_flush_next) begin
            e.flush      = 1'b1;
            m_flush_next = 0;
        end else if (m_div_left > 0) begin
            e.busy = (m_div_left > 1);
            if (ex) begin
                e.abort      = 1'b1;
                e.flush      = 1'b1;
                m_div_left   = 0;
                m_flush_next = 1;
            end else if (m_div_left > 1) begin
                e.stall    = 6'b001111;
                m_div_left = m_div_left - 1;
            end else begin
                e.done     = 1'b1;
                m_div_left = 0;
            end
        end else begin
            if (ex) begin
                e.flush      = 1'b1;
                m_flush_next = 1;
            end else if (ds) begin
                e.stall    = 6'b001111;
                m_div_left = DIV_LATENCY;
            end else if (ld && we && wa != 5'd0 && reads_dest) begin
                e.stall  = 6'b000111;
                e.bubble = 1'b1;
            end
        end
        if (e.stall[0] && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(
        input bit r, input bit re1, input bit [4:0] ra1, input bit re2, input bit [4:0] ra2,
        input bit we, input bit [4:0] wa, input bit ld, input bit ds, input bit ex);
        @(posedge clk);
        #1;
        rst            = r;
        id_read_en_1   = re1;
        id_read_addr_1 = ra1;
        id_read_en_2   = re2;
        id_read_addr_2 = ra2;
        ex_write_en    = we;
        ex_write_addr  = wa;
        ex_is_load     = ld;
        ex_div_start   = ds;
        exc_req        = ex;
        exp_q.push_back(model_step(r, re1, ra1, re2, ra2, we, wa, ld, ds, ex));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic after_monitor();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_div_stall = 0;
        n_busy      = 0;
        n_done      = 0;
        n_abort     = 0;
        n_flush     = 0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] exp_v;
        obs_t         g, e;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall == 6'b001111) n_div_stall++;
            if (div_busy)  n_busy++;
            if (div_done)  n_done++;
            if (div_abort) n_abort++;
            if (flush)     n_flush++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                e = obs_t'(exp_v);
                g = obs_t'({stall, ex_bubble, flush, div_busy, div_done, div_abort, stall_cycles});
                n_checks++;
                if (g === e) n_pass++;
                else $display("FAIL sb cyc=%0d got stall=%b bub=%b fl=%b busy=%b done=%b abort=%b sc=%0d exp stall=%b bub=%b fl=%b busy=%b done=%b abort=%b sc=%0d",
                              cyc, g.stall, g.bubble, g.flush, g.busy, g.done, g.abort, g.sc,
                              e.stall, e.bubble, e.flush, e.busy, e.done, e.abort, e.sc);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        {id_read_en_1, id_read_en_2, ex_write_en, ex_is_load, ex_div_start, exc_req} = '0;
        {id_read_addr_1, id_read_addr_2, ex_write_addr} = '0;

        // Reset state: outputs all zero while held.
        drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        drive(1, 1, 5'd8, 0, 5'd0, 1, 5'd8, 1, 1, 0);
        idle(2);

        // Load-use on port 1, then the load has moved on.
        drive(0, 1, 5'd8, 0, 5'd0, 1, 5'd8, 1, 0, 0);
        idle(1);
        // Load-use on port 2 with port 1 reading another register.
        drive(0, 1, 5'd3, 1, 5'd17, 1, 5'd17, 1, 0, 0);
        // $0 destination, disabled read port, non-load, no write, 1-bit address difference.
        drive(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0);
        drive(0, 0, 5'd8, 0, 5'd8, 1, 5'd8, 1, 0, 0);
        drive(0, 1, 5'd8, 0, 5'd0, 1, 5'd8, 0, 0, 0);
        drive(0, 1, 5'd8, 0, 5'd0, 0, 5'd8, 1, 0, 0);
        drive(0, 1, 5'd24, 0, 5'd0, 1, 5'd8, 1, 0, 0);
        idle(1);

        // Full divide from a fresh reset: 32 stall cycles, 31 busy, one done.
        drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        after_monitor();
        clear_counts();
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
        // Hazard inputs during the divide must not produce a bubble.
        drive(0, 1, 5'd8, 0, 5'd0, 1, 5'd8, 1, 0, 0);
        idle(DIV_LATENCY + 1);
        after_monitor();
        check("div_stall_cycles", n_div_stall, DIV_LATENCY);
        check("div_busy_cycles", n_busy, DIV_LATENCY - 1);
        check("div_done_pulses", n_done, 1);
        check("stall_cycles_after_div", stall_cycles, DIV_LATENCY);

        // Exception on the 10th divide-wait cycle, held into the flush cycle.
        clear_counts();
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
        idle(9);
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
        idle(DIV_LATENCY);
        after_monitor();
        check("abort_pulses", n_abort, 1);
        check("abort_no_done", n_done, 0);
        check("abort_flush_cycles", n_flush, 2);

        // Exception and hazard together in IDLE; exc_req held through FLUSH.
        clear_counts();
        drive(0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 1, 1, 1);
        drive(0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 1, 1, 1);
        idle(2);
        after_monitor();
        check("exc_flush_cycles", n_flush, 2);
        check("exc_no_div", n_div_stall, 0);

        // Reset pulsed mid-divide.
        clear_counts();
        drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
        idle(5);
        drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
        idle(DIV_LATENCY + 2);
        after_monitor();
        check("rst_no_done", n_done, 0);
        check("rst_no_abort", n_abort, 0);
        check("rst_stall_cycles", stall_cycles, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 15) == 0);
        end
        idle(2);
        after_monitor();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
